// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default pointer width, synchronizer depth and
// binary/Gray conversion helpers used by both clock-domain controllers.
package fifo_pkg;

    localparam int ADDRSIZE_DEFAULT = 4;
    localparam int SYNC_STAGES      = 2;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin = gray;
        for (int i = 1; i < 32; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/graycode_gen.sv
// Shared binary-to-Gray converter, purely combinational, WIDTH bits wide.
module graycode_gen
    import fifo_pkg::*;
#(
    parameter int WIDTH = ADDRSIZE_DEFAULT + 1
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    logic [31:0] gray_wide;

    assign gray_wide = bin2gray(32'(bin));
    assign gray      = gray_wide[WIDTH-1:0];

endmodule

// File: rtl/write_inc_gray2bin_conv.sv
// Gray-to-binary converter for the synced read pointer; each binary bit is the
// XOR of all Gray bits at and above its position.
module gray2bin_conv #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/write_inc.sv
// Write-domain pointer, full/almost_full and level controller for the async FIFO.
// Optional sticky overflow detection is built when WR_OVERFLOW_EN is defined.
module write_inc
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE    = ADDRSIZE_DEFAULT,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                wclk,
    input  logic                rst,
    input  logic                signal_write,
    input  logic [ADDRSIZE:0]   graycode_rptr,
    output logic                full,
    output logic                almost_full,
    output logic [ADDRSIZE-1:0] write_address,
    output logic                write_en,
    output logic [ADDRSIZE:0]   graycode_wptr,
    output logic [ADDRSIZE:0]   wr_level,
    output logic                wr_overflow
);

    localparam int W = ADDRSIZE + 1;

    logic [W-1:0] write_counter;
    logic [W-1:0] next_write;
    logic [W-1:0] next_gray;
    logic [W-1:0] rptr_s1;
    logic [W-1:0] rptr_s2;
    logic [W-1:0] rbin;
    logic [W-1:0] level_next;
    logic         accept;
    logic         next_full;

    assign accept        = signal_write & ~full;
    assign write_en      = accept;
    assign write_address = write_counter[ADDRSIZE-1:0];
    assign next_write    = write_counter + W'(accept);

    graycode_gen #(.WIDTH(W)) u_next_gray (
        .bin  (next_write),
        .gray (next_gray)
    );

    gray2bin_conv #(.WIDTH(W)) u_rptr_bin (
        .gray (rptr_s2),
        .bin  (rbin)
    );

    // Full means the write pointer is exactly one lap ahead of the synced read pointer.
    assign next_full  = (next_gray == {~rptr_s2[ADDRSIZE:ADDRSIZE-1], rptr_s2[ADDRSIZE-2:0]});
    assign level_next = next_write - rbin;

    always_ff @(posedge wclk) begin
        if (rst) begin
            write_counter <= '0;
            graycode_wptr <= '0;
            rptr_s1       <= '0;
            rptr_s2       <= '0;
            full          <= 1'b0;
            almost_full   <= 1'b0;
            wr_level      <= '0;
        end else begin
            if (accept) begin
                write_counter <= next_write;
                graycode_wptr <= next_gray;
            end
            rptr_s1     <= graycode_rptr;
            rptr_s2     <= rptr_s1;
            full        <= next_full;
            wr_level    <= level_next;
            almost_full <= (level_next >= W'(AFULL_LEVEL));
        end
    end

`ifdef WR_OVERFLOW_EN
    logic overflow_q;

    always_ff @(posedge wclk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (signal_write & full) begin
            overflow_q <= 1'b1;
        end
    end

    assign wr_overflow = overflow_q;
`else
    assign wr_overflow = 1'b0;
`endif

endmodule
